// File: rtl/hwce_wload_streamer.sv
`default_nettype none
// ============================================================================
// hwce_wload_streamer: valid/ready weight stream -> TCDM write requests at
// consecutive word addresses. Optional HWCE_WLOAD_CHECKSUM_EN adds chk_xor.
// Revision: 1.0
// ============================================================================
module hwce_wload_streamer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_clear,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]    cfg_n_words,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    tcdm_req,
  output logic [ADDR_WIDTH-1:0]   tcdm_add,
  output logic                    tcdm_wen,
  output logic [DATA_WIDTH-1:0]   tcdm_wdata,
  output logic [DATA_WIDTH/8-1:0] tcdm_be,
  input  logic                    tcdm_gnt,
  input  logic                    tcdm_r_valid,
  output logic                    busy,
  output logic                    done
`ifdef HWCE_WLOAD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]   chk_xor
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [OUT_W:0]        MAX_OUT    = (OUT_W + 1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH-1:0]  accepted_q, accepted_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] add_q, add_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic [OUT_W-1:0]      outst_q, outst_d;

  logic                  grant;
  logic                  accept;
  logic                  drain_done;
  logic                  rsp;
  logic [OUT_W:0]        committed;

  assign grant      = req_q & tcdm_gnt;
  assign rsp        = tcdm_r_valid & (outst_q != '0);
  // The held word counts against the window so grants never exceed MAX_OUTSTANDING.
  assign committed  = {1'b0, outst_q} + {{OUT_W{1'b0}}, req_q};
  assign in_ready   = (state_q == S_RUN) && (accepted_q < n_q) &&
                      (!req_q || tcdm_gnt) && (committed < MAX_OUT);
  assign accept     = in_valid & in_ready;
  assign drain_done = (state_q == S_DRAIN) && (outst_q == '0);

  assign tcdm_req   = req_q;
  assign tcdm_add   = add_q;
  assign tcdm_wdata = wdata_q;
  assign tcdm_wen   = 1'b0;
  assign tcdm_be    = '1;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q | drain_done;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    accepted_d = accepted_q;
    issued_d   = issued_q;
    addr_d     = addr_q;
    add_d      = add_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    done_d     = 1'b0;
    outst_d    = outst_q;

    if (grant && !rsp)      outst_d = outst_q + OUT_W'(1);
    else if (!grant && rsp) outst_d = outst_q - OUT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_n_words != '0) begin
            n_d        = cfg_n_words;
            addr_d     = cfg_base_addr & ALIGN_MASK;
            accepted_d = '0;
            issued_d   = '0;
            state_d    = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          req_d      = 1'b1;
          add_d      = addr_q;
          wdata_d    = in_data;
          addr_d     = addr_q + STRIDE;
          accepted_d = accepted_q + CNT_WIDTH'(1);
        end else if (grant) begin
          req_d = 1'b0;
        end
        if (grant) issued_d = issued_q + CNT_WIDTH'(1);
        if ((issued_q == n_q) && !req_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cfg_clear) begin
      state_d    = S_IDLE;
      req_d      = 1'b0;
      accepted_d = '0;
      issued_d   = '0;
      outst_d    = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      accepted_q <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      add_q      <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      accepted_q <= accepted_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      add_q      <= add_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      done_q     <= done_d;
      outst_q    <= outst_d;
    end
  end

`ifdef HWCE_WLOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (cfg_clear || ((state_q == S_IDLE) && cfg_start)) chk_d = '0;
    else if (grant)                                      chk_d = chk_q ^ wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end

  assign chk_xor = chk_q;
`endif

endmodule
`default_nettype wire
